go_kill_master: RTL and testbench

- Initiator side of the go/kill/done job handshake; drives go and kill into a counting worker FSM and watches its done output.
- Launches a job on host request, applies a watchdog timeout, and kills and retries a hung job up to MAX_RETRY times.
- Reports a single-cycle ok or fail result to the host.
- Sits between the host control logic and one worker instance.

---
 rtl/go_kill_pkg.sv | 19 +
 rtl/gk_down_timer.sv | 29 ++
 rtl/go_kill_master.sv | 131 +++++++++++++
 tb/tb_go_kill_master.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/go_kill_pkg.sv
// Shared types and defaults for the go/kill job master.
// Optional stats outputs are enabled by GO_KILL_MASTER_STATS_EN.
package go_kill_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        KILL   = 3'd3,
        COOL   = 3'd4
    } gk_state_t;

    localparam int DEF_TIMEOUT    = 128;
    localparam int DEF_KILL_HOLD  = 2;
    localparam int DEF_MAX_RETRY  = 2;
    localparam int DEF_CW         = 8;
    localparam int WORKER_RUN_LEN = 100;

endpackage

// File: rtl/gk_down_timer.sv
// Loadable down-counter that holds at zero; used for watchdog and kill hold.
module gk_down_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] value,
    input  logic          en,
    output logic          zero
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && count != '0) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/go_kill_master.sv
// Initiator of the go/kill/done job handshake with watchdog and retry.
// Define GO_KILL_MASTER_STATS_EN to add saturating result counters.
module go_kill_master
    import go_kill_pkg::*;
#(
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int KILL_HOLD = DEF_KILL_HOLD,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int CW        = DEF_CW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       done_in,
    output logic       go,
    output logic       kill,
    output logic       busy,
    output logic       ok,
    output logic       fail,
    output logic       cancelled,
    output logic [1:0] retries
`ifdef GO_KILL_MASTER_STATS_EN
    ,
    output logic [7:0] ok_count,
    output logic [7:0] fail_count,
    output logic [7:0] retry_count
`endif
);

    // Watchdog loads one less so WAIT lasts exactly TIMEOUT cycles.
    localparam logic [CW-1:0] WD_INIT   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(KILL_HOLD - 1);

    gk_state_t state, state_next;
    logic done_q, done_q2, done_rise;
    logic cancel_flag;
    logic wd_zero, hold_zero, hold_load;
    logic retry_ok, relaunch;

    assign done_rise = done_q & ~done_q2;
    assign retry_ok  = int'(retries) < MAX_RETRY;
    assign relaunch  = (state == COOL) && !cancel_flag && retry_ok;
    assign hold_load = (state_next == KILL) && (state != KILL);

    gk_down_timer #(.CW(CW)) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .load  (state == LAUNCH),
        .value (WD_INIT),
        .en    (state == WAIT),
        .zero  (wd_zero)
    );

    gk_down_timer #(.CW(CW)) u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .value (HOLD_INIT),
        .en    (state == KILL),
        .zero  (hold_zero)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = LAUNCH;
            LAUNCH: state_next = cancel ? KILL : WAIT;
            WAIT: begin
                if (done_rise)    state_next = IDLE;
                else if (cancel)  state_next = KILL;
                else if (wd_zero) state_next = KILL;
            end
            KILL:   if (hold_zero) state_next = COOL;
            COOL:   state_next = relaunch ? LAUNCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign go   = (state == LAUNCH);
    assign kill = (state == KILL);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            done_q2     <= 1'b0;
            cancel_flag <= 1'b0;
            retries     <= 2'd0;
            ok          <= 1'b0;
            fail        <= 1'b0;
            cancelled   <= 1'b0;
        end else begin
            state     <= state_next;
            done_q    <= done_in;
            done_q2   <= done_q;
            ok        <= (state == WAIT) && done_rise;
            fail      <= (state == COOL) && !relaunch;
            cancelled <= (state == COOL) && cancel_flag;
            if (state == IDLE && start) begin
                retries     <= 2'd0;
                cancel_flag <= 1'b0;
            end else begin
                if (relaunch && retries != 2'd3)
                    retries <= retries + 2'd1;
                if ((state == LAUNCH && cancel) ||
                    (state == WAIT && !done_rise && cancel))
                    cancel_flag <= 1'b1;
            end
        end
    end

`ifdef GO_KILL_MASTER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_count    <= 8'd0;
            fail_count  <= 8'd0;
            retry_count <= 8'd0;
        end else begin
            if (ok && ok_count != 8'hff)
                ok_count <= ok_count + 8'd1;
            if (fail && fail_count != 8'hff)
                fail_count <= fail_count + 8'd1;
            if (relaunch && retry_count != 8'hff)
                retry_count <= retry_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_go_kill_master.sv
// Bench for go_kill_master: job-level reference model, directed and random jobs.
// Stats checks are compiled in with GO_KILL_MASTER_STATS_EN.
module tb_go_kill_master;
    import go_kill_pkg::*;

    localparam int T  = DEF_TIMEOUT;
    localparam int H  = DEF_KILL_HOLD;
    localparam int MR = DEF_MAX_RETRY;
    localparam int P  = T + H + 2;

    logic clk = 1'b0;
    logic reset, start, cancel, done_in;
    logic go, kill, busy, ok, fail, cancelled;
    logic [1:0] retries;
`ifdef GO_KILL_MASTER_STATS_EN
    logic [7:0] ok_count, fail_count, retry_count;
    int m_ok = 0, m_fail = 0, m_retry = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int resp [3];
    int can_att, can_x;
    bit rnd_start, idle_cancel;

    always #5 clk = ~clk;

    go_kill_master dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cancel    (cancel),
        .done_in   (done_in),
        .go        (go),
        .kill      (kill),
        .busy      (busy),
        .ok        (ok),
        .fail      (fail),
        .cancelled (cancelled),
        .retries   (retries)
`ifdef GO_KILL_MASTER_STATS_EN
        ,
        .ok_count    (ok_count),
        .fail_count  (fail_count),
        .retry_count (retry_count)
`endif
    );

    task automatic chk(input string tag, input int c,
                       input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, c, obs, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Plans one job from the worker responses, then drives and checks it.
    task automatic run_job();
        bit gexp [0:511];
        bit kexp [0:511];
        int e, ret, g, a, rel;
        bit eok, ecan, dn;
        for (int i = 0; i < 512; i++) begin
            gexp[i] = 1'b0;
            kexp[i] = 1'b0;
        end
        e = 0; ret = 0; eok = 1'b0; ecan = 1'b0;
        for (int at = 0; at <= MR; at++) begin
            g = 1 + at * P;
            gexp[g] = 1'b1;
            ret = at;
            if (resp[at] >= 0 && resp[at] < T &&
                !(can_att == at && can_x < resp[at] + 1)) begin
                eok = 1'b1;
                e = g + resp[at] + 2;
                break;
            end
            if (can_att == at) begin
                for (int k = 1; k <= H; k++) kexp[g + can_x + k] = 1'b1;
                ecan = 1'b1;
                e = g + can_x + H + 2;
                break;
            end
            for (int k = 1; k <= H; k++) kexp[g + T + k] = 1'b1;
            e = g + T + H + 2;
        end

        for (int c = 0; c <= e + 1; c++) begin
            @(posedge clk);
            #1;
            start  = (c == 0) ||
                     (rnd_start && c > 0 && c < e && $urandom_range(3) == 0);
            cancel = 1'b0;
            dn     = 1'b0;
            if (c >= 1 && c < e) begin
                a   = (c - 1) / P;
                rel = (c - 1) % P;
                if (resp[a] >= 0 && rel >= resp[a] && rel <= T + H) dn = 1'b1;
                if (can_att == a && rel == can_x) cancel = 1'b1;
            end
            if (c == e + 1 && idle_cancel) cancel = 1'b1;
            done_in = dn;
            @(negedge clk);
            chk("go", c, go, gexp[c]);
            chk("kill", c, kill, kexp[c]);
            chk("busy", c, busy, c >= 1 && c < e);
            chk("ok", c, ok, c == e && eok);
            chk("fail", c, fail, c == e && !eok);
            if (gexp[c]) chk("retries_at_go", c, retries, (c - 1) / P);
            if (c == e) begin
                chk("retries", c, retries, ret);
                if (!eok) chk("cancelled", c, cancelled, ecan);
            end
        end
        start = 1'b0;
        cancel = 1'b0;
        done_in = 1'b0;
`ifdef GO_KILL_MASTER_STATS_EN
        m_ok    = sat(m_ok + int'(eok));
        m_fail  = sat(m_fail + int'(!eok));
        m_retry = sat(m_retry + ret);
`endif
    endtask

    task automatic set_job(input int r0, input int r1, input int r2,
                           input int ca, input int cx, input bit rs);
        resp[0] = r0; resp[1] = r1; resp[2] = r2;
        can_att = ca; can_x = cx;
        rnd_start = rs; idle_cancel = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; done_in = 1'b0;
        @(negedge clk);
        chk("rst_go", 0, go, 1'b0);
        chk("rst_kill", 0, kill, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_ok", 0, ok, 1'b0);
        chk("rst_fail", 0, fail, 1'b0);
        chk("rst_cancelled", 0, cancelled, 1'b0);
        chk("rst_retries", 0, retries, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        set_job(WORKER_RUN_LEN + 1, -1, -1, -1, 0, 1'b0); run_job();
        set_job(-1, 50, -1, -1, 0, 1'b0);                 run_job();
        set_job(-1, -1, -1, -1, 0, 1'b0);                 run_job();
        set_job(-1, -1, -1, 0, 10, 1'b0);                 run_job();
        set_job(T - 1, -1, -1, -1, 0, 1'b1);              run_job();
        set_job(T, 0, -1, -1, 0, 1'b0);                   run_job();
        set_job(-1, -1, 5, 0, 0, 1'b1);                   run_job();
        set_job(-1, -1, 20, 2, 3, 1'b0);                  run_job();

        for (int j = 0; j < 20; j++) begin
            for (int a = 0; a < 3; a++)
                resp[a] = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(T + H));
            can_att = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : -1;
            can_x = int'($urandom_range(T));
            rnd_start = 1'b1;
            idle_cancel = 1'($urandom_range(1));
            run_job();
        end

`ifdef GO_KILL_MASTER_STATS_EN
        chk("ok_count", 0, ok_count, m_ok);
        chk("fail_count", 0, fail_count, m_fail);
        chk("retry_count", 0, retry_count, m_retry);
`endif

        // Reset in the middle of the first kill burst.
        for (int c = 0; c <= T + 2; c++) begin
            @(posedge clk);
            #1 start = (c == 0);
            @(negedge clk);
        end
        chk("kill_before_reset", T + 2, kill, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_kill", 0, kill, 1'b0);
        chk("async_busy", 0, busy, 1'b0);
        chk("async_go", 0, go, 1'b0);
        chk("async_retries", 0, retries, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 0, busy, 1'b0);
        chk("post_rst_ok", 0, ok, 1'b0);
        chk("post_rst_fail", 0, fail, 1'b0);
`ifdef GO_KILL_MASTER_STATS_EN
        m_ok = 0; m_fail = 0; m_retry = 0;
        chk("rst_ok_count", 0, ok_count, 8'd0);
        chk("rst_fail_count", 0, fail_count, 8'd0);
        chk("rst_retry_count", 0, retry_count, 8'd0);
        for (int j = 0; j < 300; j++) begin
            set_job(0, -1, -1, -1, 0, 1'b0);
            run_job();
        end
        chk("sat_ok_count", 0, ok_count, m_ok);
        chk("sat_ok_is_255", 0, ok_count, 8'd255);
        chk("sat_fail_count", 0, fail_count, m_fail);
`endif

        set_job(3, -1, -1, -1, 0, 1'b0); run_job();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
